// File: rtl/wca_bus_arbiter.sv
// wca_bus_arbiter: round-robin tristate bus arbiter with turnaround gaps and max-hold preemption.
// Define WCA_ARB_FIXED_PRIO_EN for lowest-index-wins selection instead of round-robin.
module wca_bus_arbiter #(
    parameter int NREQ        = 4,
    parameter int OWNW        = 2,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 64,
    parameter int CNTW        = 8
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_enable,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_grant,
    output logic [NREQ-1:0] o_oe,
    output logic [OWNW-1:0] o_owner,
    output logic            o_busy,
    output logic            o_preempt
);
    typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

    state_t          r_state, w_state;
    logic [NREQ-1:0] r_grant, w_grant;
    logic [NREQ-1:0] r_oe, w_oe;
    logic [OWNW-1:0] r_owner, w_owner;
    logic [OWNW-1:0] r_ptr, w_ptr;
    logic [CNTW-1:0] r_hold, w_hold;
    logic [3:0]      r_turn, w_turn;
    logic            r_preempt, w_preempt;
    logic [OWNW-1:0] w_win;
    logic            w_own_req, w_force;

`ifdef WCA_ARB_FIXED_PRIO_EN
    always_comb begin
        w_win = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (i_req[i]) w_win = OWNW'(i);
    end
`else
    // Descending scan so the nearest requester after the pointer is assigned last.
    always_comb begin
        w_win = '0;
        for (int i = NREQ; i >= 1; i--)
            if (i_req[(int'(r_ptr) + i) % NREQ]) w_win = OWNW'((int'(r_ptr) + i) % NREQ);
    end
`endif

    assign w_own_req = i_req[r_owner];
    // >= rather than == so an owner that outlived MAX_HOLD uncontended is preempted once contention shows up.
    assign w_force   = (MAX_HOLD != 0) && (r_hold >= CNTW'(MAX_HOLD - 1)) && w_own_req
                       && (|(i_req & ~r_grant));

    always_comb begin
        w_state   = r_state;
        w_grant   = r_grant;
        w_oe      = r_oe;
        w_owner   = r_owner;
        w_ptr     = r_ptr;
        w_hold    = r_hold;
        w_turn    = r_turn;
        w_preempt = 1'b0;
        case (r_state)
            S_IDLE: if (i_enable && |i_req) begin
                w_state = S_OWN;
                w_grant = NREQ'(1) << w_win;
                w_owner = w_win;
                w_hold  = '0;
            end
            S_OWN: if (!w_own_req || w_force) begin
                w_state   = (TURN_CYCLES == 0) ? S_IDLE : S_TURN;
                w_grant   = '0;
                w_oe      = '0;
                w_ptr     = r_owner;
                w_turn    = '0;
                w_preempt = w_force;
            end else begin
                w_oe   = r_grant;
                w_hold = (&r_hold) ? r_hold : r_hold + 1'b1;
            end
            S_TURN: begin
                w_state = (r_turn == 4'(TURN_CYCLES - 1)) ? S_IDLE : S_TURN;
                w_turn  = r_turn + 1'b1;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_oe      <= '0;
            r_owner   <= '0;
            r_ptr     <= OWNW'(NREQ - 1);
            r_hold    <= '0;
            r_turn    <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_grant   <= w_grant;
            r_oe      <= w_oe;
            r_owner   <= w_owner;
            r_ptr     <= w_ptr;
            r_hold    <= w_hold;
            r_turn    <= w_turn;
            r_preempt <= w_preempt;
        end
    end

    assign o_grant   = r_grant;
    assign o_oe      = r_oe;
    assign o_owner   = r_owner;
    assign o_busy    = (r_state != S_IDLE);
    assign o_preempt = r_preempt;
endmodule

// File: tb/tb_wca_bus_arbiter.sv
// tb_wca_bus_arbiter: directed stimulus checked every cycle against an ownership-level model.
module tb_wca_bus_arbiter;
    localparam int NREQ = 4, OWNW = 2, TURN = 1, MAXH = 8, CNTW = 8;

    logic            clk, rst, en;
    logic [NREQ-1:0] req, grant, oe;
    logic [OWNW-1:0] owner;
    logic            busy, preempt;
    int              vectors = 0, miscompares = 0;

    // Model: current owner (-1 when none), ownership cycle index, turnaround cycles left.
    int m_cur, m_n, m_left, m_last, m_owner;
    bit m_pre;

    wca_bus_arbiter #(.NREQ(NREQ), .OWNW(OWNW), .TURN_CYCLES(TURN), .MAX_HOLD(MAXH), .CNTW(CNTW)) dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_req(req),
        .o_grant(grant), .o_oe(oe), .o_owner(owner), .o_busy(busy), .o_preempt(preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_cur = -1; m_n = 0; m_left = 0; m_last = NREQ - 1; m_owner = 0; m_pre = 1'b0;
    endtask

    task automatic model_step();
        bit others, forced;
        int w;
        if (rst) begin
            model_reset();
            return;
        end
        m_pre = 1'b0;
        if (m_cur >= 0) begin
            others = (req & ~(NREQ'(1) << m_cur)) != 0;
            forced = MAXH != 0 && m_n >= MAXH && req[m_cur] && others;
            if (!req[m_cur] || forced) begin
                m_last = m_cur; m_cur = -1; m_left = TURN; m_pre = forced;
            end else m_n++;
        end else if (m_left > 0) m_left--;
        else if (en && req != 0) begin
            w = -1;
`ifdef WCA_ARB_FIXED_PRIO_EN
            for (int k = 0; k < NREQ; k++) if (w < 0 && req[k]) w = k;
`else
            for (int k = 1; k <= NREQ; k++) if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
`endif
            m_cur = w; m_owner = w; m_n = 1;
        end
    endtask

    task automatic compare_model();
        logic [NREQ-1:0] eg, eo;
        logic            eb;
        eg = (m_cur >= 0) ? NREQ'(1) << m_cur : '0;
        eo = (m_cur >= 0 && m_n >= 2) ? eg : '0;
        eb = m_cur >= 0 || m_left > 0;
        vectors++;
        if (grant !== eg || oe !== eo || owner !== OWNW'(m_owner) || busy !== eb || preempt !== m_pre) begin
            miscompares++;
            $display("FAIL model t=%0t got grant=%b oe=%b owner=%0d busy=%b preempt=%b, exp grant=%b oe=%b owner=%0d busy=%b preempt=%b",
                     $time, grant, oe, owner, busy, preempt, eg, eo, m_owner, eb, m_pre);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic reset_dut();
        rst = 1'b1; req = '0; en = 1'b1;
        model_reset();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (grant == '0 && n < 12) begin tick(); n++; end
        if (grant == '0) begin
            miscompares++;
            $display("FAIL wait_grant t=%0t got=0 exp=nonzero", $time);
        end
    endtask

    initial begin
        int ord[5] = '{0, 1, 2, 3, 0};
        rst = 1'b1; en = 1'b0; req = '0;
        model_reset();
        tick();
        lit("reset_grant", 32'(grant), 0);
        lit("reset_busy", 32'(busy), 0);
        reset_dut();

        req = 4'b0001;
        tick(); lit("single_grant", 32'(grant), 4'b0001); lit("single_oe_first", 32'(oe), 0);
        tick(); lit("single_oe", 32'(oe), 4'b0001); lit("single_busy", 32'(busy), 1);
        req = 4'b0000;
        tick(); lit("release_grant", 32'(grant), 0); lit("turn_busy", 32'(busy), 1);
        tick(); lit("idle_busy", 32'(busy), 0);

        reset_dut();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_grant();
            lit("rr_order", 32'(grant), 32'(1) << ord[n]);
            tick(); tick();
            req = 4'b1111 & ~grant;
            tick();
            req = 4'b1111;
        end
        req = '0;
        repeat (4) tick();

        reset_dut();
        req = 4'b0001;
        tick(); tick(); tick();
        req = 4'b0101;
        repeat (5) tick();
        lit("hold8_grant", 32'(grant), 4'b0001);
        tick(); lit("preempt_pulse", 32'(preempt), 1); lit("preempt_grant", 32'(grant), 0);
        tick(); lit("preempt_clear", 32'(preempt), 0);
        tick(); lit("preempt_next", 32'(grant), 4'b0100);
        req = '0;
        repeat (3) tick();

        reset_dut();
        req = 4'b0001;
        repeat (20) begin tick(); if (m_cur >= 0) lit("uncontended_preempt", 32'(preempt), 0); end
        lit("uncontended_grant", 32'(grant), 4'b0001);
        req = 4'b1001;
        tick(); lit("late_preempt", 32'(preempt), 1);
        req = '0;
        repeat (3) tick();

        reset_dut();
        en = 1'b0; req = 4'b0010;
        repeat (3) tick();
        lit("disabled_grant", 32'(grant), 0);
        en = 1'b1;
        tick(); lit("enabled_grant", 32'(grant), 4'b0010);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        lit("async_grant", 32'(grant), 0);
        lit("async_oe", 32'(oe), 0);
        lit("async_busy", 32'(busy), 0);
        model_reset();
        tick();
        rst = 1'b0; req = '0;
        tick();

`ifdef WCA_ARB_FIXED_PRIO_EN
        reset_dut();
        req = 4'b1010;
        repeat (3) begin
            wait_grant();
            lit("fixed_prio", 32'(grant), 4'b0010);
            tick();
            req = 4'b1000;
            tick();
            req = 4'b1010;
        end
        req = '0;
        repeat (4) tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
